// File: rtl/muldiv_pkg.sv
// Shared RV32M decode constants and operand-class helpers for the iterative
// multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is signed for every op except MULHU, DIVU, REMU
  function automatic logic f3_signed_a(input logic [2:0] f3);
    return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV, REM
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring
// divide on operand magnitudes, then a single sign-fix cycle.
//
// Handshake: start is sampled only when the unit is idle or in DONE (busy=0);
// a start while busy is ignored. done pulses for exactly one cycle and result
// is valid from then until the next accepted start. flush/rst abort at once.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div0_q, div0_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                sgn_a, sgn_b;
  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     div_diff;
  logic                q_bit;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, remd, fix_result;

  assign sgn_a = f3_signed_a(funct3);
  assign sgn_b = f3_signed_b(funct3);

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);

  // Divide: acc[XLEN-1:0] shifts dividend bits out and quotient bits in
  assign div_diff = {rem_q, acc_q[XLEN-1]} - {2'b00, mag_b_q};
  assign q_bit    = ~div_diff[XLEN+1];

  // A zero divisor leaves |rs1| in rem_q, so the sign fix restores rs1 exactly
  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = div0_q ? '1 : (neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign remd = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_comb begin
    fix_result = '0;
    case (op_q)
      F3_MUL:                      fix_result = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             fix_result = quot;
      default:                     fix_result = remd;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    count_d   = count_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d      = funct3;
          acc_d     = {{XLEN{1'b0}}, abs_mag(rs1, sgn_a)};
          mag_b_d   = abs_mag(rs2, sgn_b);
          rem_d     = '0;
          neg_res_d = (sgn_a & rs1[XLEN-1]) ^ (sgn_b & rs2[XLEN-1]);
          neg_rem_d = sgn_a & rs1[XLEN-1];
          div0_d    = (rs2 == '0);
          count_d   = '0;
          state_d   = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        count_d = count_q + CNT_W'(1);
        if (f3_is_div(op_q)) begin
          rem_d              = q_bit ? div_diff[XLEN:0] : {rem_q[XLEN-1:0], acc_q[XLEN-1]};
          acc_d[XLEN-1:0]    = {acc_q[XLEN-2:0], q_bit};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        if (count_q == CNT_W'(XLEN-1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_result;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      count_q   <= count_d;
      result_q  <= result_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. The ALU control unit decodes ordinary ALU operations. For `opcode`=OP with `funct7`=0000001, the EX stage instead raises `start` to this block with `funct3` and both operands. The block runs a fixed-latency 32-step shift-add or restoring-divide sequence. It stalls the pipeline through `busy` and returns the result with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; count width is `$clog2(XLEN)+1`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `flush`  in  1  synchronous abort of the in-flight operation
- `funct3`  in  3  M-op select: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
- `rs1`  in  XLEN  operand A (dividend)
- `rs2`  in  XLEN  operand B (divisor)
- `busy`  out  1  high in CALC and FIX; the hazard unit stalls IF/ID/EX on it
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle
- `result`  out  XLEN  registered result, held until the next accepted `start`

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with `start`=1 → CALC. On that edge the block latches:
  - `funct3`
  - the magnitudes of `rs1` and `rs2`
  - sign flags, and `rs2`==0
  - `count`=0
- IDLE/DONE with `start`=0: DONE → IDLE; IDLE stays IDLE.
- Signedness of operands:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitude of a signed operand is its two's-complement absolute value. |0x80000000| = 0x80000000 as unsigned.
- CALC, multiply: one step per edge. If multiplier LSB=1, add the multiplicand into the upper half of a 2·XLEN accumulator, then shift right one bit.
- CALC, divide: restoring division, one quotient bit per edge. The remainder register is XLEN+1 bits wide.
- `count` increments each CALC edge. The state moves to FIX on the edge where `count` reaches XLEN-1, which is the 32nd step.
- FIX → DONE, with a single-edge result write:
  - MUL: low XLEN bits of the sign-corrected product.
  - MULH, MULHSU, MULHU: high XLEN bits of the sign-corrected product.
  - Product sign correction: negate the full 2·XLEN product when the operand signs differ (signed operands only).
  - DIV/DIVU: quotient, negated if the signed operand signs differ.
  - REM/REMU: remainder, negated if the signed dividend is negative.
- Divide by zero: quotient = all ones for DIV and DIVU; remainder = original `rs1`. These override the sign correction.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. The magnitude path yields this naturally; it must not be special-cased to anything else.
- `flush` has priority over `start` and the FSM: → IDLE, no `done`, `result` unchanged.
  - `flush` and `start` on the same edge: flush wins, start is dropped.
- `start` in CALC or FIX is ignored. The operation in flight is unaffected.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `count`=0. Reset mid-operation aborts identically to `flush`, but also clears `result`.
- `start` sampled at edge E0:
  - `busy`=1 from after E0 through the FIX cycle, i.e. after E0 to after E33.
  - FIX→DONE at E33; `done`=1 and `result` valid in the cycle after E33.
  - `busy`=0 in the DONE cycle.
- Fixed latency is 33 cycles from the start edge to `done` for every `funct3`, including divide by zero.
- Back-to-back operation: `start` in the DONE cycle is accepted at E34 and the next `done` follows 33 cycles later. There is no idle bubble.
- `busy` and `done` are combinational decodes of the state register only. Neither depends combinationally on any input.

## Structure
- `defines.v` gains `F3_MUL` … `F3_REMU` and `F7_MULDIV` (0000001).
  - The FSM state encodings are local parameters of `muldiv_unit`, not shared.
- No sub-module is needed; a single module of about 200 lines.
  - A combinational `abs` helper function sits inside the module.

## Test plan
- MUL `rs1`=7, `rs2`=0xFFFFFFFD → `done` exactly 33 cycles after the start edge, `result`=0xFFFFFFEB; `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; REMU 0x80000000/0 → 0x80000000; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `flush` at cycle 10 of a DIV → IDLE next cycle, no `done` pulse, `result` keeps the previous value. A `start` asserted mid-CALC is ignored and does not alter the result.
- Back-to-back: a second `start` in the DONE cycle gives a second `done` 33 cycles later with the correct value. `rst` mid-CALC → `busy`=0, `result`=0, `done` never pulses.
